fixed_p_std_sdiv_seq: RTL and testbench

FIXED_P_STD_SDIV_SEQ -- requirements
Module: fixed_p_std_sdiv_seq

---
 rtl/fixed_p_pkg.sv | 15 +
 rtl/fixed_p_sdiv_step.sv | 22 ++
 rtl/fixed_p_std_sdiv_seq.sv | 135 +++++++++++++
 tb/tb_fixed_p_std_sdiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_p_pkg.sv
// Shared types and helpers for the sequential signed fixed-point divider.
package fixed_p_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold 0..ITERS.
  function automatic int iter_cnt_width(input int iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/fixed_p_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module fixed_p_sdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Remainder stays below the divisor (at most 2^(WIDTH-1)), so either
  // selected value fits back into WIDTH bits.
  assign shifted  = {rem, dvd_bit};
  assign diff     = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~diff[WIDTH+1];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/fixed_p_std_sdiv_seq.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Define FIXED_P_SDIV_SAT_EN to saturate overflow and divide-by-zero results.
module fixed_p_std_sdiv_seq
  import fixed_p_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int ITERS = WIDTH + FRACT_WIDTH;
  localparam int CW    = iter_cnt_width(ITERS);

  localparam logic [ITERS-1:0] MAG_LIM = ITERS'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(ITERS - 1);

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_cfg
    $error("fixed_p_std_sdiv_seq: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rem, div_mag;
  logic [ITERS-1:0]  dq;            // dividend shifts out the top, quotient in the bottom
  logic              neg_q, neg_l, dbz;

  logic              load, finish;
  logic [WIDTH-1:0]  rem_next, mag_l, mag_r;
  logic              q_bit;
  logic [ITERS-1:0]  q_fin;
  logic [WIDTH-1:0]  q_low, wrapped, result;
  logic              ovf;

  fixed_p_sdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dq[ITERS-1]),
    .divisor  (div_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Two's-complement negate of -2^(WIDTH-1) is exact as an unsigned magnitude.
  assign mag_l = left[WIDTH-1]  ? -left  : left;
  assign mag_r = right[WIDTH-1] ? -right : right;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_next = RUN;
        load       = 1'b1;
      end
      RUN: if (dbz || cnt == LAST) begin
        state_next = DONE;
        finish     = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == DONE);

  // Result formation uses the final quotient bit before it is registered.
  always_comb begin
    q_fin   = {dq[ITERS-2:0], q_bit};
    q_low   = q_fin[WIDTH-1:0];
    wrapped = neg_q ? (WIDTH'(0) - q_low) : q_low;
    ovf     = neg_q ? (q_fin > MAG_LIM) : (q_fin >= MAG_LIM);
`ifdef FIXED_P_SDIV_SAT_EN
    if (dbz)
      result = neg_l ? MIN_NEG : MAX_POS;
    else if (ovf)
      result = neg_q ? MIN_NEG : MAX_POS;
    else
      result = wrapped;
`else
    result = dbz ? '0 : wrapped;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      div_mag     <= '0;
      neg_q       <= 1'b0;
      neg_l       <= 1'b0;
      dbz         <= 1'b0;
      out         <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        cnt     <= '0;
        rem     <= '0;
        dq      <= {mag_l, {FRACT_WIDTH{1'b0}}};
        div_mag <= mag_r;
        neg_q   <= left[WIDTH-1] ^ right[WIDTH-1];
        neg_l   <= left[WIDTH-1];
        dbz     <= (right == '0);
      end else if (state == RUN && !dbz) begin
        cnt <= cnt + CW'(1);
        rem <= rem_next;
        dq  <= {dq[ITERS-2:0], q_bit};
      end
      if (finish) begin
        out         <= result;
        overflow    <= dbz ? 1'b0 : ovf;
        div_by_zero <= dbz;
      end
    end
  end

endmodule

// File: tb/tb_fixed_p_std_sdiv_seq.sv
// Self-checking bench for fixed_p_std_sdiv_seq in Q4.4; honours FIXED_P_SDIV_SAT_EN.
module tb_fixed_p_std_sdiv_seq;

  localparam int W = 8;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    logic       dbz;
    int         lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out;
  logic         done, overflow, div_by_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  fixed_p_std_sdiv_seq #(.WIDTH(8), .INT_WIDTH(4), .FRACT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .left        (left),
    .right       (right),
    .out         (out),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer division truncates toward zero.
  function automatic exp_t model(input logic [7:0] l, input logic [7:0] r);
    exp_t   e;
    longint sl, sr, q;
    sl = longint'($signed(l));
    sr = longint'($signed(r));
    if (sr == 0) begin
      e.dbz = 1'b1;
      e.ovf = 1'b0;
      e.lat = 2;
`ifdef FIXED_P_SDIV_SAT_EN
      e.out = (sl < 0) ? 8'h80 : 8'h7F;
`else
      e.out = 8'h00;
`endif
    end else begin
      q     = (sl * 16) / sr;
      e.dbz = 1'b0;
      e.ovf = (q > 127) || (q < -128);
      e.lat = 13;
      e.out = q[7:0];
`ifdef FIXED_P_SDIV_SAT_EN
      if (e.ovf) e.out = (q > 0) ? 8'h7F : 8'h80;
`endif
    end
    return e;
  endfunction

  // Wait up to a bounded number of cycles for done; lat counts the go-sampling edge as 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic compare_result(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_out"}, out, e.out);
    check({tag, "_ovf"}, overflow, e.ovf);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] l, input logic [7:0] r, input exp_t e);
    int lat;
    sb.push_back(e);
    @(negedge clk);
    left  = l;
    right = r;
    go    = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(lat);
    compare_result(tag, lat);
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic v, input logic z, input int lat);
    exp_t e;
    e.out = o; e.ovf = v; e.dbz = z; e.lat = lat;
    return e;
  endfunction

  initial begin
    int   lat, gap, n_done;
    logic [7:0] rl, rr;

    // Reset state
    #12;
    check("rst_out", out, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed values
    do_op("pos_1p5_div_0p5", 8'h18, 8'h08, mk(8'h30, 0, 0, 13));
    do_op("neg_1p5_div_0p5", 8'hE8, 8'h08, mk(8'hD0, 0, 0, 13));
    do_op("trunc_pos",       8'h10, 8'h30, mk(8'h05, 0, 0, 13));
    do_op("trunc_neg",       8'hF0, 8'h30, mk(8'hFB, 0, 0, 13));
`ifdef FIXED_P_SDIV_SAT_EN
    do_op("overflow",        8'h70, 8'h04, mk(8'h7F, 1, 0, 13));
    do_op("div_zero",        8'h10, 8'h00, mk(8'h7F, 0, 1, 2));
    do_op("div_zero_neg",    8'hF0, 8'h00, mk(8'h80, 0, 1, 2));
`else
    do_op("overflow",        8'h70, 8'h04, mk(8'hC0, 1, 0, 13));
    do_op("div_zero",        8'h10, 8'h00, mk(8'h00, 0, 1, 2));
    do_op("div_zero_neg",    8'hF0, 8'h00, mk(8'h00, 0, 1, 2));
`endif
    do_op("min_neg_div_one", 8'h80, 8'h10, mk(8'h80, 0, 0, 13));
    do_op("min_neg_div_m1",  8'h80, 8'hF0, model(8'h80, 8'hF0));

    // Reset mid-RUN abandons the operation
    do_op("pre_reset", 8'h18, 8'h08, mk(8'h30, 0, 0, 13));
    @(negedge clk);
    left = 8'h70; right = 8'h10; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_rst_out", out, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_ovf", overflow, 0);
    check("midrun_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset  = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 0);
    do_op("post_reset", 8'h18, 8'h08, mk(8'h30, 0, 0, 13));

    // go held high, operands changed mid-RUN
    sb.push_back(mk(8'h30, 0, 0, 13));
    @(negedge clk);
    left = 8'h18; right = 8'h08; go = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    left = 8'h10; right = 8'h30;
    #1;
    lat = 1;
    wait_done(lat);
    lat = lat + 2;
    compare_result("held_go_first", lat);
    sb.push_back(mk(8'h05, 0, 0, 14));
    gap = 1;
    while (!done && gap < 200) begin
      @(posedge clk); #1;
      gap++;
    end
    go = 1'b0;
    compare_result("held_go_second", gap);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      rl = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      do_op($sformatf("rand_%0d", i), rl, rr, model(rl, rr));
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
